// File: rtl/noc_local_injector.sv
// noc_local_injector: sends header, size and payload flits from a local core onto a mesh router Local port.
// The bench flow control is tx/credit_i; payload words are buffered in a small FIFO.
module noc_local_injector #(
  parameter int TAM_FLIT   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [TAM_FLIT-1:0] cmd_target,
  input  logic [TAM_FLIT-1:0] cmd_size,
  input  logic                payload_valid,
  output logic                payload_ready,
  input  logic [TAM_FLIT-1:0] payload_data,
  output logic                clock_tx,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  input  logic                credit_i,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_sent
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;
  state_t state;
  logic [TAM_FLIT-1:0] target, remaining;
  logic [TAM_FLIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, xfer;
  assign clock_tx = clock;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign payload_ready = count < FULL;
  assign push = payload_valid && payload_ready;
  // tx depends only on registered state, so an async reset drops it at once
  assign tx = (state == HEADER) || (state == SIZE) || (state == PAYLOAD && count != '0);
  assign xfer = tx && credit_i;
  assign pop = xfer && state == PAYLOAD;
  // remaining still holds the full size while the size flit is shown
  assign data_out = state == HEADER ? target :
                    state == SIZE ? remaining :
                    state == PAYLOAD ? mem[rd_ptr] : '0;
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= payload_data;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_sent  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      case (state)
        IDLE: if (cmd_valid) begin
          target    <= cmd_target;
          remaining <= cmd_size;
          state     <= HEADER;
        end
        HEADER: if (xfer) state <= SIZE;
        SIZE: if (xfer) begin
          state <= remaining == '0 ? IDLE : PAYLOAD;
          if (remaining == '0) pkt_sent <= pkt_sent + 1'b1;
        end
        PAYLOAD: if (xfer) begin
          remaining <= remaining - 1'b1;
          if (remaining == 1) begin
            state    <= IDLE;
            pkt_sent <= pkt_sent + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector: scoreboard bench for noc_local_injector; expected flits are queued as
// commands and payload are driven and compared against every tx/credit transfer.
module tb_noc_local_injector;
  logic        clock = 0, reset = 1;
  logic        cmd_valid = 0, cmd_ready;
  logic [15:0] cmd_target = 0, cmd_size = 0;
  logic        payload_valid = 0, payload_ready;
  logic [15:0] payload_data = 0;
  logic        clock_tx, tx, credit_i = 1, busy;
  logic [15:0] data_out;
  logic [7:0]  pkt_sent;
  logic [15:0] exp_q[$], mq[$];
  logic [15:0] mon_e;
  logic [7:0]  exp_pkts = 0;
  int          need = 0;
  int          n_checks = 0, n_fail = 0;

  noc_local_injector #(.TAM_FLIT(16), .FIFO_DEPTH(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_size(cmd_size), .payload_valid(payload_valid),
    .payload_ready(payload_ready), .payload_data(payload_data), .clock_tx(clock_tx),
    .tx(tx), .data_out(data_out), .credit_i(credit_i), .busy(busy), .pkt_sent(pkt_sent)
  );

  always #5 clock = ~clock;

  // a transfer happens at the next rising edge when tx and credit_i are both high here
  always @(negedge clock) begin
    if (!reset && tx && credit_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL flit_unexpected: got %h, required no flit", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_out !== mon_e) begin
          n_fail++;
          $display("FAIL flit_data: got %h, required %h", data_out, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed();
    while (need > 0 && mq.size() > 0) begin
      exp_q.push_back(mq.pop_front());
      need--;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    payload_valid = 1;
    payload_data = w;
    if (payload_ready) mq.push_back(w);
    tick();
    payload_valid = 0;
    feed();
  endtask

  task automatic send_cmd(input logic [15:0] t, input logic [15:0] s);
    int k;
    for (k = 0; k < 1000 && !cmd_ready; k++) tick();
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got %b, required 1", cmd_ready);
    end
    cmd_valid = 1;
    cmd_target = t;
    cmd_size = s;
    tick();
    cmd_valid = 0;
    exp_q.push_back(t);
    exp_q.push_back(s);
    need += int'(s);
    exp_pkts++;
    feed();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500 && !(exp_q.size() == 0 && cmd_ready); k++) tick();
    n_checks++;
    if (!(exp_q.size() == 0 && cmd_ready)) begin
      n_fail++;
      $display("FAIL idle_timeout: got %0d flits pending cmd_ready=%b, required 0 and 1", exp_q.size(), cmd_ready);
    end
    n_checks++;
    if (pkt_sent !== exp_pkts) begin
      n_fail++;
      $display("FAIL pkt_sent: got %0d, required %0d", pkt_sent, exp_pkts);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset = 0;
    tick();
    n_checks++;
    if ({tx, data_out, cmd_ready, busy, pkt_sent, payload_ready} !== {1'b0, 16'h0, 1'b1, 1'b0, 8'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got tx=%b data=%h rdy=%b busy=%b sent=%0d pr=%b, required 0 0000 1 0 0 1",
               tx, data_out, cmd_ready, busy, pkt_sent, payload_ready);
    end
  endtask

  task automatic test_basic();
    credit_i = 1;
    push_word(16'h00A1);
    push_word(16'h00A2);
    push_word(16'h00A3);
    send_cmd(16'h0102, 16'd3);
    n_checks++;
    if (tx !== 1'b1 || data_out !== 16'h0102) begin
      n_fail++;
      $display("FAIL header_latency: got tx=%b data=%h, required 1 0102", tx, data_out);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tx !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back_tx: got %b at flit %0d, required 1", tx, i);
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_last: got %b, required 0", busy);
    end
    wait_idle();
  endtask

  task automatic test_stall();
    push_word(16'h00A1);
    push_word(16'h00A2);
    push_word(16'h00A3);
    send_cmd(16'h0102, 16'd3);
    tick();
    credit_i = 0;
    repeat (4) begin
      n_checks++;
      if (tx !== 1'b1 || data_out !== 16'h0003) begin
        n_fail++;
        $display("FAIL stall_hold: got tx=%b data=%h, required 1 0003", tx, data_out);
      end
      tick();
    end
    credit_i = 1;
    wait_idle();
  endtask

  task automatic test_zero_size();
    push_word(16'h00B1);
    push_word(16'h00B2);
    send_cmd(16'h0000, 16'd0);
    wait_idle();
    send_cmd(16'h0203, 16'd2);
    wait_idle();
  endtask

  task automatic test_trickle();
    send_cmd(16'h0304, 16'd4);
    for (int i = 0; i < 4; i++) begin
      repeat (2) tick();
      n_checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bubble: got tx=%b busy=%b, required 0 1", tx, busy);
      end
      tick();
      push_word(16'h0D00 + 16'(i));
    end
    wait_idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push_word(16'h0C00 + 16'(i));
    n_checks++;
    if (payload_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b, required 0", payload_ready);
    end
    push_word(16'hDEAD);
    send_cmd(16'h0405, 16'd8);
    repeat (2) tick();
    n_checks++;
    if (payload_ready !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL full_before_pop: got ready=%b tx=%b, required 0 1", payload_ready, tx);
    end
    tick();
    n_checks++;
    if (payload_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_pop: got %b, required 1", payload_ready);
    end
    repeat (3) tick();
    push_word(16'h0E00);
    wait_idle();
    credit_i = 0;
    for (int i = 1; i < 7; i++) push_word(16'h0E00 + 16'(i));
    n_checks++;
    if (payload_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_at_7: got %b, required 1", payload_ready);
    end
    push_word(16'h0E07);
    n_checks++;
    if (payload_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_at_8: got %b, required 0", payload_ready);
    end
    credit_i = 1;
    send_cmd(16'h0506, 16'd8);
    wait_idle();
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 1; i <= 5; i++) push_word(16'h0F00 + 16'(i));
    send_cmd(16'h0607, 16'd5);
    repeat (3) tick();
    n_checks++;
    if (tx !== 1'b1 || data_out !== 16'h0F02) begin
      n_fail++;
      $display("FAIL before_abort: got tx=%b data=%h, required 1 0f02", tx, data_out);
    end
    #2 reset = 1;
    #1;
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort_tx: got %b, required 0", tx);
    end
    exp_q.delete();
    mq.delete();
    need = 0;
    exp_pkts = 0;
    repeat (2) tick();
    reset = 0;
    tick();
    n_checks++;
    if (pkt_sent !== exp_pkts || cmd_ready !== 1'b1 || payload_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_abort: got sent=%0d rdy=%b pr=%b, required %0d 1 1", pkt_sent, cmd_ready, payload_ready, exp_pkts);
    end
    send_cmd(16'h0708, 16'd1);
    repeat (2) tick();
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_flushed: got tx=%b, required 0", tx);
    end
    push_word(16'h0C01);
    wait_idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 254; i++) send_cmd(16'(i), 16'd0);
    wait_idle();
    n_checks++;
    if (pkt_sent !== 8'hFF) begin
      n_fail++;
      $display("FAIL pkt_sent_max: got %0d, required 255", pkt_sent);
    end
    send_cmd(16'h0909, 16'd0);
    wait_idle();
    n_checks++;
    if (pkt_sent !== 8'h00) begin
      n_fail++;
      $display("FAIL pkt_sent_wrap: got %0d, required 0", pkt_sent);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_trickle();
    test_full();
    test_reset_mid_packet();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_flits: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
